// File: rtl/nes_bus_mem_model_if.sv
// CPU-side bus and preload port bundle for nes_bus_mem_model.
// master = CPU/bench driving the bus, slave = the memory model.
interface nes_bus_mem_model_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 8,
   parameter int DEPTH  = 512
);
   localparam int LD_AW = $clog2(DEPTH);

   logic [ADDR_W-1:0] Addr_bus;
   logic [DATA_W-1:0] wdata;
   logic              we;
   logic [DATA_W-1:0] Data_bus;
   logic              rvalid;
   logic              ld_valid;
   logic [LD_AW-1:0]  ld_addr;
   logic [DATA_W-1:0] ld_data;
   logic              ld_ready;
   logic              ld_done;
   logic              oob;
   logic              wp_err;
   logic              trap;
   logic [15:0]       access_cnt;

   modport master (
      output Addr_bus, wdata, we, ld_valid, ld_addr, ld_data, ld_done,
      input  Data_bus, rvalid, ld_ready, oob, wp_err, trap, access_cnt
   );

   modport slave (
      input  Addr_bus, wdata, we, ld_valid, ld_addr, ld_data, ld_done,
      output Data_bus, rvalid, ld_ready, oob, wp_err, trap, access_cnt
   );
endinterface

// File: rtl/nes_bus_mem_model.sv
// Loadable RAM window on the CPU bus with pipelined reads, out-of-window fill and a loop trap.
// Define MEM_WRPROT_EN to make words [0,ROM_WORDS) read-only to CPU writes in RUN.
module nes_bus_mem_model #(
   parameter int                ADDR_W     = 16,
   parameter int                DATA_W     = 8,
   parameter int                DEPTH      = 512,
   parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
   parameter int                RD_LAT     = 1,
   parameter logic [DATA_W-1:0] FILL_BYTE  = 8'hff,
   parameter int                ROM_WORDS  = 256,
   parameter logic [ADDR_W-1:0] TRAP_ADDR  = '0,
   parameter int                TRAP_COUNT = 8
) (
   input logic                clk_ph2,
   input logic                rst,
   nes_bus_mem_model_if.slave bus
);
   localparam int AW = $clog2(DEPTH);

   typedef enum logic {ST_LOAD, ST_RUN} state_t;
   state_t state_reg, state_next;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] ram_q;

   logic [ADDR_W-1:0] offset;
   logic [AW-1:0]     word_idx;
   logic              in_win;
   logic              prot_hit;

   logic              mem_we;
   logic [AW-1:0]     mem_waddr;
   logic [DATA_W-1:0] mem_wdata;
   logic              rd_issue;
   logic              oob_next;
   logic              wp_next;
   logic              trap_hit;
   logic [15:0]       trap_cnt_next;

   logic              win_reg;
   logic              rd_vld_reg;
   logic              oob_reg;
   logic              wp_err_reg;
   logic              trap_reg;
   logic [15:0]       trap_cnt_reg;
   logic [15:0]       access_cnt_reg;

   // Read pipe view: element 0 is the issue-edge register, the rest are delay stages.
   logic [DATA_W-1:0] stg_dat [RD_LAT];
   logic              stg_vld [RD_LAT];

   assign offset   = bus.Addr_bus - BASE_ADDR;
   assign word_idx = offset[AW-1:0];
   assign in_win   = (offset < ADDR_W'(DEPTH));

`ifdef MEM_WRPROT_EN
   assign prot_hit = (offset < ADDR_W'(ROM_WORDS));
`else
   assign prot_hit = 1'b0;
`endif

   always_ff @(posedge clk_ph2) begin
      if (rst) begin
         state_reg <= ST_LOAD;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      mem_we     = 1'b0;
      mem_waddr  = '0;
      mem_wdata  = '0;
      rd_issue   = 1'b0;
      oob_next   = 1'b0;
      wp_next    = 1'b0;
      case (state_reg)
         ST_LOAD: begin
            // ld_ready is high throughout LOAD, so ld_valid alone completes a handshake
            if (bus.ld_valid) begin
               mem_we    = 1'b1;
               mem_waddr = bus.ld_addr;
               mem_wdata = bus.ld_data;
            end
            if (bus.ld_done) begin
               state_next = ST_RUN;
            end
         end
         ST_RUN: begin
            if (bus.we) begin
               if (!in_win) begin
                  oob_next = 1'b1;
               end else if (prot_hit) begin
                  wp_next = 1'b1;
               end else begin
                  mem_we    = 1'b1;
                  mem_waddr = word_idx;
                  mem_wdata = bus.wdata;
               end
            end else begin
               rd_issue = 1'b1;
               oob_next = !in_win;
            end
         end
         default: state_next = ST_LOAD;
      endcase
   end

   assign trap_hit      = rd_issue && (bus.Addr_bus == TRAP_ADDR);
   assign trap_cnt_next = (trap_cnt_reg == 16'hffff) ? trap_cnt_reg : trap_cnt_reg + 16'd1;

   // Contents survive reset; only the write is suppressed while rst is held.
   always_ff @(posedge clk_ph2) begin
      if (mem_we && !rst) begin
         mem[mem_waddr] <= mem_wdata;
      end
   end

   always_ff @(posedge clk_ph2) begin
      if (rd_issue) begin
         ram_q <= mem[word_idx];
      end
   end

   always_ff @(posedge clk_ph2) begin
      if (rst) begin
         win_reg        <= 1'b0;
         rd_vld_reg     <= 1'b0;
         oob_reg        <= 1'b0;
         wp_err_reg     <= 1'b0;
         trap_reg       <= 1'b0;
         trap_cnt_reg   <= '0;
         access_cnt_reg <= '0;
      end else begin
         rd_vld_reg <= rd_issue;
         oob_reg    <= oob_next;
         wp_err_reg <= wp_next;
         if (rd_issue) begin
            win_reg <= in_win;
         end
         if ((state_reg == ST_RUN) && (access_cnt_reg != 16'hffff)) begin
            access_cnt_reg <= access_cnt_reg + 16'd1;
         end
         if (trap_hit) begin
            trap_cnt_reg <= trap_cnt_next;
            if ((TRAP_COUNT != 0) && (trap_cnt_next == 16'(TRAP_COUNT))) begin
               trap_reg <= 1'b1;
            end
         end
      end
   end

   // Out-of-window reads (and the post-reset state) present the fill byte.
   assign stg_dat[0] = win_reg ? ram_q : FILL_BYTE;
   assign stg_vld[0] = rd_vld_reg;

   genvar gi;
   generate
      for (gi = 1; gi < RD_LAT; gi++) begin : g_stage
         logic [DATA_W-1:0] dat_reg;
         logic              vld_reg;
         // Data only advances with a valid entry so Data_bus holds across write cycles.
         always_ff @(posedge clk_ph2) begin
            if (rst) begin
               dat_reg <= FILL_BYTE;
               vld_reg <= 1'b0;
            end else begin
               vld_reg <= stg_vld[gi-1];
               if (stg_vld[gi-1]) begin
                  dat_reg <= stg_dat[gi-1];
               end
            end
         end
         assign stg_dat[gi] = dat_reg;
         assign stg_vld[gi] = vld_reg;
      end
   endgenerate

   assign bus.Data_bus   = stg_dat[RD_LAT-1];
   assign bus.rvalid     = stg_vld[RD_LAT-1];
   assign bus.ld_ready   = (state_reg == ST_LOAD);
   assign bus.oob        = oob_reg;
   assign bus.wp_err     = wp_err_reg;
   assign bus.trap       = trap_reg;
   assign bus.access_cnt = access_cnt_reg;
endmodule

// File: tb/tb_nes_bus_mem_model.sv
// Bench for nes_bus_mem_model: RD_LAT=1 and RD_LAT=3 instances share one stimulus stream
// and are compared every cycle against a history-based model of the bus.
`timescale 1ns/1ps
module tb_nes_bus_mem_model;
   localparam int         DEPTH = 512;
   localparam logic [7:0] FILL  = 8'hff;
`ifdef MEM_WRPROT_EN
   localparam bit PROT = 1'b1;
`else
   localparam bit PROT = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   nes_bus_mem_model_if #(.ADDR_W(16), .DATA_W(8), .DEPTH(DEPTH)) bus1 ();
   nes_bus_mem_model_if #(.ADDR_W(16), .DATA_W(8), .DEPTH(DEPTH)) bus3 ();

   assign bus3.Addr_bus = bus1.Addr_bus;
   assign bus3.wdata    = bus1.wdata;
   assign bus3.we       = bus1.we;
   assign bus3.ld_valid = bus1.ld_valid;
   assign bus3.ld_addr  = bus1.ld_addr;
   assign bus3.ld_data  = bus1.ld_data;
   assign bus3.ld_done  = bus1.ld_done;

   nes_bus_mem_model #(
      .ADDR_W(16), .DATA_W(8), .DEPTH(DEPTH), .BASE_ADDR(16'h0000), .RD_LAT(1),
      .FILL_BYTE(8'hff), .ROM_WORDS(256), .TRAP_ADDR(16'h0006), .TRAP_COUNT(3)
   ) dut1 (
      .clk_ph2(clk),
      .rst    (rst),
      .bus    (bus1)
   );

   nes_bus_mem_model #(
      .ADDR_W(16), .DATA_W(8), .DEPTH(DEPTH), .BASE_ADDR(16'h0000), .RD_LAT(3),
      .FILL_BYTE(8'hff), .ROM_WORDS(256), .TRAP_ADDR(16'h0006), .TRAP_COUNT(3)
   ) dut3 (
      .clk_ph2(clk),
      .rst    (rst),
      .bus    (bus3)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Behavioural model: memory image plus a per-edge record of issued reads.
   logic [7:0]  mm [DEPTH];
   bit          rec_vld [8192];
   logic [7:0]  rec_dat [8192];
   int          edge_n   = -1;
   int          last_rst = -1;
   bit          started  = 1'b0;
   bit          run_st   = 1'b0;
   int unsigned acc      = 0;
   int          tcnt     = 0;
   bit          trap_m   = 1'b0;
   bit          oob_m    = 1'b0;
   bit          wp_m     = 1'b0;
   logic [15:0] offv;
   int          off;
   bit          inw;

   initial forever begin
      @(posedge clk);
      edge_n++;
      rec_vld[edge_n] = 1'b0;
      rec_dat[edge_n] = FILL;
      oob_m = 1'b0;
      wp_m  = 1'b0;
      if (rst) begin
         run_st   = 1'b0;
         acc      = 0;
         tcnt     = 0;
         trap_m   = 1'b0;
         last_rst = edge_n;
         started  = 1'b1;
      end else if (!run_st) begin
         if (bus1.ld_valid) mm[bus1.ld_addr] = bus1.ld_data;
         if (bus1.ld_done) run_st = 1'b1;
      end else begin
         offv = bus1.Addr_bus - 16'h0000;
         off  = int'(offv);
         inw  = (off < DEPTH);
         if (acc < 65535) acc++;
         if (bus1.we) begin
            if (!inw) oob_m = 1'b1;
            else if (PROT && off < 256) wp_m = 1'b1;
            else mm[off] = bus1.wdata;
         end else begin
            rec_vld[edge_n] = 1'b1;
            rec_dat[edge_n] = inw ? mm[off] : FILL;
            oob_m = !inw;
            if (bus1.Addr_bus == 16'h0006) begin
               tcnt++;
               if (tcnt == 3) trap_m = 1'b1;
            end
         end
      end
   end

   // Output seen after edge n for latency lat comes from the read issued at edge n-lat+1;
   // Data_bus shows the newest read at or before that edge since the last reset.
   function automatic logic [8:0] exp_out(input int lat);
      int         k;
      logic       v;
      logic [7:0] d;
      k = edge_n - lat + 1;
      v = 1'b0;
      d = FILL;
      if (k > last_rst) v = rec_vld[k];
      for (int j = k; j > last_rst; j--) begin
         if (rec_vld[j]) begin
            d = rec_dat[j];
            break;
         end
      end
      return {v, d};
   endfunction

   logic [8:0] e1, e3;

   initial forever begin
      @(negedge clk);
      if (started) begin
         e1 = exp_out(1);
         e3 = exp_out(3);
         chk("rvalid_l1",   bus1.rvalid,     e1[8]);
         chk("data_l1",     bus1.Data_bus,   e1[7:0]);
         chk("rvalid_l3",   bus3.rvalid,     e3[8]);
         chk("data_l3",     bus3.Data_bus,   e3[7:0]);
         chk("ld_ready_l1", bus1.ld_ready,   !run_st);
         chk("ld_ready_l3", bus3.ld_ready,   !run_st);
         chk("oob_l1",      bus1.oob,        oob_m);
         chk("oob_l3",      bus3.oob,        oob_m);
         chk("wp_err_l1",   bus1.wp_err,     wp_m);
         chk("wp_err_l3",   bus3.wp_err,     wp_m);
         chk("trap_l1",     bus1.trap,       trap_m);
         chk("trap_l3",     bus3.trap,       trap_m);
         chk("acc_l1",      bus1.access_cnt, acc);
         chk("acc_l3",      bus3.access_cnt, acc);
      end
   end

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic drive(input logic [15:0] a, input logic w, input logic [7:0] d);
      bus1.Addr_bus = a;
      bus1.we       = w;
      bus1.wdata    = d;
   endtask

   logic [15:0] ra;

   initial begin
      bus1.Addr_bus = '0;
      bus1.we       = 1'b0;
      bus1.wdata    = '0;
      bus1.ld_valid = 1'b0;
      bus1.ld_addr  = '0;
      bus1.ld_data  = '0;
      bus1.ld_done  = 1'b0;
      rst = 1'b1;
      cyc();
      cyc();
      chk("rst_data",    bus1.Data_bus,   8'hff);
      chk("rst_ldready", bus1.ld_ready,   1);
      chk("rst_cnt",     bus3.access_cnt, 0);
      rst = 1'b0;

      // Preload every word; CPU traffic during LOAD must be ignored.
      for (int i = 0; i < DEPTH; i++) begin
         bus1.ld_valid = 1'b1;
         bus1.ld_addr  = 9'(i);
         case (i)
            0:       bus1.ld_data = 8'hA2;
            1:       bus1.ld_data = 8'h0F;
            2:       bus1.ld_data = 8'h9A;
            5:       bus1.ld_data = 8'h33;
            default: bus1.ld_data = 8'($urandom);
         endcase
         bus1.ld_done = (i == DEPTH - 1);
         drive(16'($urandom_range(0, 700)), 1'($urandom_range(0, 1)), 8'($urandom));
         cyc();
      end
      bus1.ld_valid = 1'b0;
      bus1.ld_done  = 1'b0;
      chk("load_nocount", bus1.access_cnt, 0);
      chk("load_ready",   bus1.ld_ready,   0);

      // Back-to-back reads, latency 1 and 3
      drive(16'h0000, 1'b0, 8'h00); cyc();
      chk("t1_d0", bus1.Data_bus, 8'hA2); chk("t1_v0", bus1.rvalid, 1); chk("t2_v0", bus3.rvalid, 0);
      drive(16'h0001, 1'b0, 8'h00); cyc();
      chk("t1_d1", bus1.Data_bus, 8'h0F); chk("t2_v1", bus3.rvalid, 0);
      drive(16'h0002, 1'b0, 8'h00); cyc();
      chk("t1_d2", bus1.Data_bus, 8'h9A); chk("t2_v2", bus3.rvalid, 1); chk("t2_d2", bus3.Data_bus, 8'hA2);

      // Out-of-window read and write
      drive(16'h0400, 1'b0, 8'h00); cyc();
      chk("t3_rdata", bus1.Data_bus, 8'hff); chk("t3_rvalid", bus1.rvalid, 1); chk("t3_roob", bus1.oob, 1);
      drive(16'h0400, 1'b1, 8'h77); cyc();
      chk("t3_woob", bus1.oob, 1); chk("t3_wvalid", bus1.rvalid, 0); chk("t3_whold", bus1.Data_bus, 8'hff);

      // Write then read, and the protected region
      drive(16'h0105, 1'b1, 8'h55); cyc();
      chk("t4_nooob", bus1.oob, 0); chk("t4_nowp", bus1.wp_err, 0);
      drive(16'h0105, 1'b0, 8'h00); cyc();
      chk("t4_rd", bus1.Data_bus, 8'h55);
      drive(16'h0005, 1'b1, 8'h55); cyc();
      chk("t4_wp", bus1.wp_err, PROT);
      drive(16'h0005, 1'b0, 8'h00); cyc();
      chk("t4_rom", bus1.Data_bus, PROT ? 8'h33 : 8'h55);
      chk("t4_cnt", bus1.access_cnt, 9);

      // Loop trap: reads 6,7,0 repeated; fires on the third read of 6
      for (int r = 0; r < 9; r++) begin
         drive((r % 3 == 0) ? 16'h0006 : (r % 3 == 1) ? 16'h0007 : 16'h0000, 1'b0, 8'h00);
         cyc();
         chk("t5_trap", bus1.trap, (r >= 6));
      end

      // Reset mid-stream keeps memory contents
      drive(16'h0000, 1'b0, 8'h00); cyc();
      drive(16'h0001, 1'b0, 8'h00); cyc();
      rst = 1'b1;
      drive(16'h0002, 1'b0, 8'h00); cyc();
      chk("t6_v1", bus1.rvalid, 0); chk("t6_v3", bus3.rvalid, 0);
      chk("t6_ready", bus1.ld_ready, 1); chk("t6_cnt", bus1.access_cnt, 0); chk("t6_trap", bus1.trap, 0);
      rst = 1'b0;
      bus1.ld_done = 1'b1;
      drive(16'h0006, 1'b0, 8'h00); cyc();
      bus1.ld_done = 1'b0;
      drive(16'h0000, 1'b0, 8'h00); cyc();
      chk("t6_keep", bus1.Data_bus, 8'hA2); chk("t6_kvalid", bus1.rvalid, 1);

      // Randomized traffic including resets and reloads
      for (int c = 0; c < 2500; c++) begin
         rst = ($urandom_range(0, 199) == 0);
         bus1.ld_valid = 1'($urandom_range(0, 1));
         bus1.ld_addr  = 9'($urandom);
         bus1.ld_data  = 8'($urandom);
         bus1.ld_done  = ($urandom_range(0, 7) == 0);
         case ($urandom_range(0, 3))
            0:       ra = 16'($urandom_range(0, 15));
            1:       ra = 16'($urandom_range(0, 600));
            2:       ra = 16'($urandom);
            default: ra = 16'h0006;
         endcase
         drive(ra, ($urandom_range(0, 3) == 0), 8'($urandom));
         cyc();
      end
      rst = 1'b0;
      @(negedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
